// File: rtl/stream_dmux_1to2_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_dmux_1to2_if
// Brief    : One valid/ready packet stream (data, last, route select).
// Revision : 1.0 - initial release
// ============================================================================
interface stream_dmux_1to2_if #(
    parameter int DATA_W = 8
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              sel;

    modport master (output valid, data, last, sel, input ready);
    modport slave  (input valid, data, last, sel, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_dmux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : stream_dmux_1to2
// Brief    : Packet-granular 1-to-2 valid/ready demux with one registered
//            beat per output. Define DMUX_PKT_CNT_EN for per-output counters.
// Revision : 1.0 - initial release
// ============================================================================
module stream_dmux_1to2 #(
    parameter int DATA_W = 8
`ifdef DMUX_PKT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  wire                clk,
    input  wire                rst_n,
    stream_dmux_1to2_if.slave  i_s,
    stream_dmux_1to2_if.master o_m0,
    stream_dmux_1to2_if.master o_m1,
    output logic               o_busy
`ifdef DMUX_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_pkt_cnt0,
    output logic [CNT_W-1:0]   o_pkt_cnt1
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ROUTE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_route;
    logic              w_route_nxt;
    logic              w_target;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_fill0;
    logic              w_fill1;

    logic              r_m0_valid;
    logic [DATA_W-1:0] r_m0_data;
    logic              r_m0_last;
    logic              r_m1_valid;
    logic [DATA_W-1:0] r_m1_data;
    logic              r_m1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_route <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_route <= w_route_nxt;
        end
    end

    // A first beat routes on its own sel; later beats follow the latched route.
    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        w_target    = (r_state == S_ROUTE) ? r_route : i_s.sel;
        w_s_ready   = w_target ? (!r_m1_valid || o_m1.ready)
                               : (!r_m0_valid || o_m0.ready);
        w_accept    = i_s.valid && w_s_ready;
        w_fill0     = w_accept && !w_target;
        w_fill1     = w_accept && w_target;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !i_s.last) begin
                    w_state_nxt = S_ROUTE;
                    w_route_nxt = i_s.sel;
                end
            end
            S_ROUTE: begin
                if (w_accept && i_s.last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fill wins over drain so a beat can be replaced in the same cycle it leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_valid <= 1'b0;
            r_m0_data  <= '0;
            r_m0_last  <= 1'b0;
        end else if (w_fill0) begin
            r_m0_valid <= 1'b1;
            r_m0_data  <= i_s.data;
            r_m0_last  <= i_s.last;
        end else if (o_m0.ready) begin
            r_m0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m1_valid <= 1'b0;
            r_m1_data  <= '0;
            r_m1_last  <= 1'b0;
        end else if (w_fill1) begin
            r_m1_valid <= 1'b1;
            r_m1_data  <= i_s.data;
            r_m1_last  <= i_s.last;
        end else if (o_m1.ready) begin
            r_m1_valid <= 1'b0;
        end
    end

    assign i_s.ready  = w_s_ready;
    assign o_m0.valid = r_m0_valid;
    assign o_m0.data  = r_m0_data;
    assign o_m0.last  = r_m0_last;
    assign o_m1.valid = r_m1_valid;
    assign o_m1.data  = r_m1_data;
    assign o_m1.last  = r_m1_last;
    // Outputs carry their own fixed index on sel.
    assign o_m0.sel   = 1'b0;
    assign o_m1.sel   = 1'b1;
    assign o_busy     = (r_state == S_ROUTE);

`ifdef DMUX_PKT_CNT_EN
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            if (r_m0_valid && o_m0.ready && r_m0_last) begin
                r_pkt_cnt0 <= r_pkt_cnt0 + CNT_W'(1);
            end
            if (r_m1_valid && o_m1.ready && r_m1_last) begin
                r_pkt_cnt1 <= r_pkt_cnt1 + CNT_W'(1);
            end
        end
    end

    assign o_pkt_cnt0 = r_pkt_cnt0;
    assign o_pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_dmux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_dmux_1to2
// Brief    : Directed and random stimulus for stream_dmux_1to2 against a
//            queue-based packet model (DMUX_PKT_CNT_EN adds counter checks).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stream_dmux_1to2;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef DMUX_PKT_CNT_EN
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;
`endif

    stream_dmux_1to2_if #(.DATA_W(DW)) s_bus  ();
    stream_dmux_1to2_if #(.DATA_W(DW)) m0_bus ();
    stream_dmux_1to2_if #(.DATA_W(DW)) m1_bus ();

    stream_dmux_1to2 #(.DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_s        (s_bus),
        .o_m0       (m0_bus),
        .o_m1       (m1_bus),
        .o_busy     (busy)
`ifdef DMUX_PKT_CNT_EN
        ,
        .o_pkt_cnt0 (pkt_cnt0),
        .o_pkt_cnt1 (pkt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each output queue holds the beats accepted for it but not yet taken.
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    bit          in_pkt;
    bit          route;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    bit          tgt, e_ready, e_v0, e_v1, acc;
    logic [8:0]  e_b0, e_b1;

    task automatic drive(input bit v, input logic [7:0] d, input bit sel,
                         input bit last, input bit r0, input bit r1);
        s_bus.valid  = v;
        s_bus.data   = d;
        s_bus.sel    = sel;
        s_bus.last   = last;
        m0_bus.ready = r0;
        m1_bus.ready = r1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        in_pkt = 0;
        route  = 0;
        cnt0   = '0;
        cnt1   = '0;
    endtask

    task automatic model_expect();
        @(negedge clk);
        tgt     = in_pkt ? route : s_bus.sel;
        e_ready = tgt ? (q1.size() == 0 || m1_bus.ready) : (q0.size() == 0 || m0_bus.ready);
        acc     = s_bus.valid && e_ready;
        e_v0    = (q0.size() != 0);
        e_v1    = (q1.size() != 0);
        e_b0    = '0;
        e_b1    = '0;
        if (e_v0) e_b0 = q0[0];
        if (e_v1) e_b1 = q1[0];
    endtask

    task automatic model_advance();
        if (e_v0 && m0_bus.ready) begin
            if (q0[0][8]) cnt0 = cnt0 + 16'd1;
            void'(q0.pop_front());
        end
        if (e_v1 && m1_bus.ready) begin
            if (q1[0][8]) cnt1 = cnt1 + 16'd1;
            void'(q1.pop_front());
        end
        if (acc) begin
            if (tgt) q1.push_back({s_bus.last, s_bus.data});
            else     q0.push_back({s_bus.last, s_bus.data});
            if (!in_pkt && !s_bus.last) begin
                in_pkt = 1;
                route  = s_bus.sel;
            end else if (in_pkt && s_bus.last) begin
                in_pkt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] observed();
        logic [63:0] v;
        v = '0;
        v[21:0] = {s_bus.ready, m0_bus.valid, m1_bus.valid, busy,
                   m0_bus.valid ? {m0_bus.last, m0_bus.data} : 9'h000,
                   m1_bus.valid ? {m1_bus.last, m1_bus.data} : 9'h000};
`ifdef DMUX_PKT_CNT_EN
        v[53:22] = {pkt_cnt0, pkt_cnt1};
`endif
        return v;
    endfunction

    function automatic logic [63:0] expected();
        logic [63:0] v;
        v = '0;
        v[21:0] = {e_ready, e_v0, e_v1, in_pkt, e_b0, e_b1};
`ifdef DMUX_PKT_CNT_EN
        v[53:22] = {cnt0, cnt1};
`endif
        return v;
    endfunction

    task automatic test_reset();
        drive(0, 8'h00, 0, 0, 1, 1);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({m0_bus.valid, m1_bus.valid, busy, m0_bus.data, m0_bus.last,
             m1_bus.data, m1_bus.last} !== 21'h0) begin
            errors++;
            $display("FAIL reset_hold got v0=%b v1=%b busy=%b d0=%h d1=%h required all 0",
                     m0_bus.valid, m1_bus.valid, busy, m0_bus.data, m1_bus.data);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_expect();
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL reset_idle got %h required %h", observed(), expected());
        end
        model_advance();
    endtask

    task automatic test_three_beat();
        logic [7:0] d [3];
        int idx = 0, nbusy = 0, n0 = 0;
        d = '{8'h11, 8'h22, 8'h33};
        for (int c = 0; c < 6; c++) begin
            if (idx < 3) drive(1, d[idx], 0, idx == 2, 1, 1);
            else         drive(0, 8'h00, 0, 0, 1, 1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL three_beat cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (busy) nbusy++;
            if (m0_bus.valid && m0_bus.ready) n0++;
            if (acc) idx++;
            model_advance();
        end
        checks++;
        if (nbusy != 2) begin
            errors++;
            $display("FAIL three_beat_busy got %0d cycles required 2", nbusy);
        end
        checks++;
        if (n0 != 3) begin
            errors++;
            $display("FAIL three_beat_count got %0d beats on m0 required 3", n0);
        end
`ifdef DMUX_PKT_CNT_EN
        checks++;
        if (pkt_cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL three_beat_pkt_cnt0 got %0d required 1", pkt_cnt0);
        end
`endif
    endtask

    task automatic test_sel_lock();
        int idx = 0, n0 = 0, n1 = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx == 0)      drive(1, 8'h61, 1, 0, 1, 1);
            else if (idx == 1) drive(1, 8'h62, 0, 1, 1, 1);
            else               drive(0, 8'h00, 0, 0, 1, 1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL sel_lock cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (m0_bus.valid) n0++;
            if (m1_bus.valid && m1_bus.ready) n1++;
            if (acc) idx++;
            model_advance();
        end
        checks++;
        if (n0 != 0 || n1 != 2) begin
            errors++;
            $display("FAIL sel_lock_route got m0=%0d m1=%0d beats required m0=0 m1=2", n0, n1);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d [3];
        int idx = 0, n1 = 0;
        bit r1;
        d = '{8'hA5, 8'hB6, 8'hC7};
        for (int c = 0; c < 10; c++) begin
            r1 = !(c >= 1 && c <= 4);
            if (idx < 3) drive(1, d[idx], 1, idx == 2, 1, r1);
            else         drive(0, 8'h00, 0, 0, 1, r1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (!r1) begin
                checks++;
                if ({s_bus.ready, m1_bus.valid, m1_bus.data} !== {1'b0, 1'b1, 8'hA5}) begin
                    errors++;
                    $display("FAIL backpressure_hold cyc=%0d got rdy=%b v1=%b d1=%h required rdy=0 v1=1 d1=a5",
                             c, s_bus.ready, m1_bus.valid, m1_bus.data);
                end
            end
            if (m1_bus.valid && m1_bus.ready) n1++;
            if (acc) idx++;
            model_advance();
        end
        checks++;
        if (n1 != 3) begin
            errors++;
            $display("FAIL backpressure_count got %0d beats on m1 required 3", n1);
        end
    endtask

    task automatic test_independent_drain();
        int n1 = 0;
        bit r0;
        for (int c = 0; c < 7; c++) begin
            r0 = (c >= 4);
            if (c == 0)      drive(1, 8'h5A, 0, 1, r0, 1);
            else if (c == 1) drive(1, 8'h3C, 1, 1, r0, 1);
            else             drive(0, 8'h00, 0, 0, r0, 1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL indep_drain cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if ({m0_bus.valid, m0_bus.data} !== {1'b1, 8'h5A}) begin
                    errors++;
                    $display("FAIL indep_drain_m0_hold cyc=%0d got v0=%b d0=%h required v0=1 d0=5a",
                             c, m0_bus.valid, m0_bus.data);
                end
            end
            if (c <= 3 && m1_bus.valid && m1_bus.ready) n1++;
            model_advance();
        end
        checks++;
        if (n1 != 1) begin
            errors++;
            $display("FAIL indep_drain_m1 got %0d m1 beats while m0 stalled required 1", n1);
        end
    endtask

    task automatic test_reset_mid_packet();
        int idx = 0, n0 = 0, n1 = 0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            drive(1, 8'h41 + 8'(idx), 0, 0, 1, 1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL rst_mid_pre cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (acc) idx++;
            model_advance();
        end
        drive(1, 8'h43, 0, 0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m0_bus.valid, m1_bus.valid, busy, m0_bus.data, m1_bus.data} !== 19'h0) begin
            errors++;
            $display("FAIL rst_mid_clear got v0=%b v1=%b busy=%b d0=%h d1=%h required all 0",
                     m0_bus.valid, m1_bus.valid, busy, m0_bus.data, m1_bus.data);
        end
        model_reset();
        drive(0, 8'h00, 0, 0, 1, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx == 0)      drive(1, 8'h71, 1, 0, 1, 1);
            else if (idx == 1) drive(1, 8'h72, 0, 1, 1, 1);
            else               drive(0, 8'h00, 0, 0, 1, 1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL rst_mid_post cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (m0_bus.valid) n0++;
            if (m1_bus.valid && m1_bus.ready) n1++;
            if (acc) idx++;
            model_advance();
        end
        checks++;
        if (n0 != 0 || n1 != 2) begin
            errors++;
            $display("FAIL rst_mid_route got m0=%0d m1=%0d beats required m0=0 m1=2", n0, n1);
        end
    endtask

    task automatic test_random();
        bit         cur_v = 0, cur_sel = 0, r0, r1;
        logic [7:0] cur_d = '0;
        int         rem = 0;
        for (int c = 0; c < 400; c++) begin
            if (rem == 0) rem = $urandom_range(1, 4);
            if (!cur_v) begin
                cur_v   = ($urandom_range(0, 3) != 0);
                cur_d   = 8'($urandom);
                cur_sel = 1'($urandom);
            end
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            if (c >= 390) begin
                cur_v = 0;
                r0    = 1;
                r1    = 1;
            end
            drive(cur_v, cur_d, cur_sel, rem == 1, r0, r1);
            model_expect();
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random cyc=%0d got %h required %h", c, observed(), expected());
            end
            if (acc) begin
                cur_v = 0;
                rem--;
            end
            model_advance();
        end
    endtask

    initial begin
        test_reset();
        test_three_beat();
        test_sel_lock();
        test_backpressure();
        test_independent_drain();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
